// File: rtl/adc_cap_pkg.sv
// Shared types for the ADC capture sequencer: FSM state and trigger mode encodings.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_EXT  = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: selects the compared channel, tracks the previous valid sample, evaluates the mode.
// Latency: trig_hit is combinational on the current sample; prev updates on the following edge.
// Backpressure: none; only cycles with smp_valid are considered.
module adc_trig_detect
    import adc_cap_pkg::*;
#(
    parameter int SMP_W = 12
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             arm_clr,
    input  logic             in_armed,
    input  trig_mode_t       mode,
    input  logic             chan,
    input  logic [SMP_W-1:0] level,
    input  logic             ext_trig,
    input  logic             smp_valid,
    input  logic [SMP_W-1:0] adc_ch0,
    input  logic [SMP_W-1:0] adc_ch1,
    output logic             trig_hit
);

    logic [SMP_W-1:0] smp;
    logic [SMP_W-1:0] prev;
    logic             prev_vld;
    logic             cond;

    assign smp = chan ? adc_ch1 : adc_ch0;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (arm_clr) begin
            prev_vld <= 1'b0;
        end else if (in_armed && smp_valid) begin
            prev     <= smp;
            prev_vld <= 1'b1;
        end
    end

    // Crossing modes need a previous sample, so they cannot fire on the first one after arming.
    always_comb begin
        cond = 1'b0;
        case (mode)
            TRIG_IMM:  cond = 1'b1;
            TRIG_RISE: cond = prev_vld && (prev <  level) && (smp >= level);
            TRIG_FALL: cond = prev_vld && (prev >= level) && (smp <  level);
            TRIG_EXT:  cond = ext_trig;
            default:   cond = 1'b0;
        endcase
    end

    assign trig_hit = smp_valid && in_armed && cond;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Single-shot capture of paired ADC samples into a sample RAM after a configurable trigger.
// Latency: a valid sample at cycle t is written (mem_we/addr/data) at t+1; one write per cycle.
// Backpressure: none; the RAM always accepts, cycles without smp_valid are skipped.
module adc_capture_sequencer
    import adc_cap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SMP_W  = 12
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           trig_mode,
    input  logic                 trig_chan,
    input  logic [SMP_W-1:0]     trig_level,
    input  logic                 ext_trig,
    input  logic [ADDR_W-1:0]    cap_len,
    input  logic                 smp_valid,
    input  logic [SMP_W-1:0]     adc_ch0,
    input  logic [SMP_W-1:0]     adc_ch1,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [2*SMP_W-1:0]   mem_wdata,
    output logic                 busy,
    output logic                 armed,
    output logic                 done
);

    cap_state_t        state;
    trig_mode_t        cfg_mode;
    logic              cfg_chan;
    logic [SMP_W-1:0]  cfg_level;
    logic [ADDR_W-1:0] cfg_len;
    logic [ADDR_W-1:0] wr_addr;
    logic              arm_clr;
    logic              in_armed;
    logic              trig_hit;

    assign arm_clr  = (state == IDLE) && start && !abort;
    assign in_armed = (state == ARMED);

    adc_trig_detect #(.SMP_W(SMP_W)) u_trig (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .arm_clr   (arm_clr),
        .in_armed  (in_armed),
        .mode      (cfg_mode),
        .chan      (cfg_chan),
        .level     (cfg_level),
        .ext_trig  (ext_trig),
        .smp_valid (smp_valid),
        .adc_ch0   (adc_ch0),
        .adc_ch1   (adc_ch1),
        .trig_hit  (trig_hit)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg_mode  <= TRIG_IMM;
            cfg_chan  <= 1'b0;
            cfg_level <= '0;
            cfg_len   <= '0;
            wr_addr   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            armed     <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (abort) begin
                // Abort outranks start, trigger and the write of the current sample.
                state <= IDLE;
                busy  <= 1'b0;
                armed <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cfg_mode  <= trig_mode_t'(trig_mode);
                            cfg_chan  <= trig_chan;
                            cfg_level <= trig_level;
                            cfg_len   <= cap_len;
                            wr_addr   <= '0;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            armed     <= 1'b1;
                            state     <= ARMED;
                        end
                    end
                    ARMED, CAPTURE: begin
                        if ((state == ARMED) ? trig_hit : smp_valid) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= {adc_ch1, adc_ch0};
                            armed     <= 1'b0;
                            if (wr_addr == cfg_len) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                                state   <= CAPTURE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized and directed bench for adc_capture_sequencer against a transaction-level capture model.
module tb_adc_capture_sequencer;

    localparam int N = 48;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [1:0]  trig_mode;
    logic        trig_chan;
    logic [11:0] trig_level;
    logic        ext_trig;
    logic [9:0]  cap_len;
    logic        smp_valid;
    logic [11:0] adc_ch0, adc_ch1;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        busy, armed, done;

    adc_capture_sequencer dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .trig_mode (trig_mode),
        .trig_chan (trig_chan),
        .trig_level(trig_level),
        .ext_trig  (ext_trig),
        .cap_len   (cap_len),
        .smp_valid (smp_valid),
        .adc_ch0   (adc_ch0),
        .adc_ch1   (adc_ch1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .armed     (armed),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit done;
        bit busy;
    } wr_t;

    wr_t wq[$];

    always @(negedge sys_clk) begin
        if (mem_we) wq.push_back('{cyc, int'(mem_addr), int'(mem_wdata), done, busy});
    end

    bit          s_vld[N];
    bit          s_ext[N];
    logic [11:0] s_c0[N];
    logic [11:0] s_c1[N];
    int          t_at[N];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Arms with the given config, plays stimulus [0..n), then checks every write against
    // the capture the rules predict: trigger index, then the next len+1 valid samples.
    task automatic run_cap(input int mode, input int chan, input int level, input int len,
                           input int n, input int junk_at);
        int  exp_i[$];
        int  found, prev, s, nk;
        bit  pv, hit, complete;
        found = -1;
        pv    = 0;
        prev  = 0;
        for (int i = 0; i < n; i++) begin
            if (s_vld[i]) begin
                s = chan ? int'(s_c1[i]) : int'(s_c0[i]);
                case (mode)
                    0:       hit = 1;
                    1:       hit = pv && prev <  level && s >= level;
                    2:       hit = pv && prev >= level && s <  level;
                    default: hit = s_ext[i];
                endcase
                if (hit) begin
                    found = i;
                    break;
                end
                prev = s;
                pv   = 1;
            end
        end
        if (found >= 0)
            for (int i = found; i < n && exp_i.size() < len + 1; i++)
                if (s_vld[i]) exp_i.push_back(i);
        complete = (exp_i.size() == len + 1);

        @(posedge sys_clk); #1;
        start = 1; trig_mode = 2'(mode); trig_chan = chan[0];
        trig_level = 12'(level); cap_len = 10'(len); smp_valid = 0; ext_trig = 0;
        wq.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
            if (i == 0) begin
                chk("arm_busy", busy, 1);
                chk("arm_armed", armed, 1);
                chk("arm_done_clr", done, 0);
            end
            start      = (i == junk_at);
            trig_mode  = (i == junk_at) ? 2'd0 : 2'($urandom);
            cap_len    = (i == junk_at) ? 10'd0 : 10'($urandom);
            trig_chan  = 1'($urandom);
            trig_level = 12'($urandom);
            smp_valid  = s_vld[i];
            ext_trig   = s_ext[i];
            adc_ch0    = s_c0[i];
            adc_ch1    = s_c1[i];
            t_at[i]    = cyc;
        end
        @(posedge sys_clk); #1;
        start = 0; smp_valid = 0; ext_trig = 0;
        if (!complete) begin
            abort = 1; smp_valid = 1; ext_trig = 1;
            adc_ch0 = 12'($urandom); adc_ch1 = 12'($urandom);
            @(posedge sys_clk); #1;
            abort = 0; smp_valid = 0; ext_trig = 0;
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
        end
        repeat (2) @(posedge sys_clk);
        #1;
        if (complete) begin
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_armed", armed, 0);
        end
        chk("n_writes", wq.size(), exp_i.size());
        nk = (wq.size() < exp_i.size()) ? wq.size() : exp_i.size();
        for (int k = 0; k < nk; k++) begin
            chk($sformatf("addr[%0d]", k), wq[k].addr, k);
            chk($sformatf("data[%0d]", k), wq[k].data, {8'd0, s_c1[exp_i[k]], s_c0[exp_i[k]]});
            chk($sformatf("wcyc[%0d]", k), wq[k].cyc, t_at[exp_i[k]] + 1);
            chk($sformatf("wdone[%0d]", k), wq[k].done, (k == len));
            chk($sformatf("wbusy[%0d]", k), wq[k].busy, (k != len));
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 0; s_ext[i] = 0; s_c0[i] = 0; s_c1[i] = 0;
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; trig_mode = 0; trig_chan = 0; trig_level = 0;
        ext_trig = 0; cap_len = 0; smp_valid = 0; adc_ch0 = 0; adc_ch1 = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", done, 0);
        rst = 0;

        // Immediate, ramp on ch0, valid every cycle.
        clear_stim();
        for (int i = 0; i < 8; i++) begin
            s_vld[i] = 1; s_c0[i] = 12'(i); s_c1[i] = 12'(100 + i);
        end
        run_cap(0, 0, 0, 3, 8, -1);

        // Rising on ch1 through 0x800.
        clear_stim();
        for (int i = 0; i < 8; i++) begin
            s_vld[i] = 1; s_c1[i] = 12'(12'h7FE + i); s_c0[i] = 12'(i);
        end
        run_cap(1, 1, 12'h800, 3, 8, -1);

        // Rising armed above the level: must drop below and recross.
        clear_stim();
        begin
            logic [11:0] seq [10];
            seq = '{12'h900, 12'h900, 12'h950, 12'h7F0, 12'h7F0,
                    12'h820, 12'h830, 12'h840, 12'h850, 12'h860};
            for (int i = 0; i < 10; i++) begin
                s_vld[i] = 1; s_c1[i] = seq[i]; s_c0[i] = 12'(i);
            end
        end
        run_cap(1, 1, 12'h800, 2, 10, -1);

        // Falling with valid on alternate cycles.
        clear_stim();
        for (int i = 0; i < 24; i++) begin
            s_vld[i] = (i % 2 == 0); s_c0[i] = 12'(12'hA00 - i * 12'h40); s_c1[i] = 12'(i);
        end
        run_cap(2, 0, 12'h900, 3, 24, -1);

        // External: high without valid is ignored, coincident one fires.
        clear_stim();
        for (int i = 0; i < 12; i++) begin
            s_vld[i] = (i % 2 == 1); s_c0[i] = 12'(i); s_c1[i] = 12'(50 + i);
        end
        s_ext[4] = 1; s_ext[7] = 1;
        run_cap(3, 0, 0, 1, 12, -1);

        // Single-sample capture.
        clear_stim();
        for (int i = 2; i < 6; i++) begin
            s_vld[i] = 1; s_c0[i] = 12'(7 * i); s_c1[i] = 12'(3 * i);
        end
        run_cap(0, 0, 0, 0, 6, -1);

        // Start while armed (immediate, len 0) must be ignored.
        clear_stim();
        for (int i = 0; i < 12; i++) begin
            s_vld[i] = 1; s_c0[i] = (i < 6) ? 12'h100 : 12'h900; s_c1[i] = 12'(i);
        end
        run_cap(1, 0, 12'h800, 2, 12, 3);

        // Abort together with start mid-capture.
        @(posedge sys_clk); #1;
        start = 1; trig_mode = 0; cap_len = 7; smp_valid = 0;
        @(posedge sys_clk); #1;
        start = 0; wq.delete(); smp_valid = 1; adc_ch0 = 12'h123;
        repeat (3) @(posedge sys_clk);
        #1;
        abort = 1; start = 1;
        @(posedge sys_clk); #1;
        abort = 0; start = 0;
        chk("ab_busy", busy, 0);
        chk("ab_armed", armed, 0);
        chk("ab_done", done, 0);
        repeat (4) @(posedge sys_clk);
        #1;
        smp_valid = 0;
        chk("ab_nwr", wq.size(), 3);
        chk("ab_done_late", done, 0);

        clear_stim();
        for (int i = 0; i < 6; i++) begin
            s_vld[i] = 1; s_c0[i] = 12'(40 + i); s_c1[i] = 12'(i);
        end
        run_cap(0, 0, 0, 2, 6, -1);

        // Reset mid-capture.
        @(posedge sys_clk); #1;
        start = 1; trig_mode = 0; cap_len = 15;
        @(posedge sys_clk); #1;
        start = 0; smp_valid = 1; adc_ch0 = 12'hABC; adc_ch1 = 12'h555;
        repeat (4) @(posedge sys_clk);
        #2;
        rst = 1;
        #1;
        chk("mr_we", mem_we, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_wdata", mem_wdata, 0);
        chk("mr_busy", busy, 0);
        chk("mr_armed", armed, 0);
        chk("mr_done", done, 0);
        #1;
        rst = 0;
        wq.delete();
        repeat (5) @(posedge sys_clk);
        #1;
        smp_valid = 0;
        chk("mr_nwr", wq.size(), 0);
        chk("mr_busy_late", busy, 0);

        // Randomized captures.
        for (int r = 0; r < 30; r++) begin
            int n;
            n = 20 + int'($urandom_range(0, N - 20));
            clear_stim();
            for (int i = 0; i < n; i++) begin
                s_vld[i] = ($urandom_range(0, 3) != 0);
                s_ext[i] = ($urandom_range(0, 4) == 0);
                s_c0[i]  = 12'($urandom);
                s_c1[i]  = 12'($urandom);
            end
            run_cap(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 5)), n, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences single-shot captures of the dual-channel 12-bit ADC sample stream into an external sample RAM. It sits beside the ADC→DAC datapath in `sys_clk` and taps the same rising-edge ADC samples the loopback uses. Software arms it through CSRs, and it waits for a configurable trigger. It then writes a fixed-length burst of paired channel samples and reports busy, armed and done status.

## Interface
Parameters:
- `ADDR_W`, default 10: sample RAM address width; maximum capture is 2^ADDR_W samples.
- `SMP_W`, default 12: ADC sample width, unsigned offset-binary.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse: latch configuration and arm.
- `abort`  in  1  single-cycle pulse: cancel an armed or in-progress capture.
- `trig_mode`  in  2  0 immediate, 1 rising level crossing, 2 falling level crossing, 3 external.
- `trig_chan`  in  1  channel compared for modes 1 and 2 (0 = ch0).
- `trig_level`  in  SMP_W  crossing threshold.
- `ext_trig`  in  1  external trigger, level-sensitive.
- `cap_len`  in  ADDR_W  number of samples to capture, minus one.
- `smp_valid`  in  1  the ADC sample pair is valid this cycle.
- `adc_ch0`, `adc_ch1`  in  SMP_W each  ADC samples.
- `mem_we`  out  1  RAM write strobe.
- `mem_addr`  out  ADDR_W  RAM write address.
- `mem_wdata`  out  2*SMP_W  write data, packed as {adc_ch1, adc_ch0}.
- `busy`  out  1  high in ARMED or CAPTURE.
- `armed`  out  1  high in ARMED.
- `done`  out  1  sticky completion flag; cleared by the next accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - ARMED: waits for a trigger.
  - CAPTURE: writes samples.
- Transitions:
  - IDLE → ARMED on `start`. The latched configuration is `trig_mode`, `trig_chan`, `trig_level` and `cap_len`. `done` clears and the previous-sample-valid flag clears.
  - ARMED → CAPTURE on the trigger sample. That sample is written to address 0.
    - If `cap_len` = 0, the FSM goes ARMED → IDLE directly and sets `done`.
  - CAPTURE → IDLE after the write to address `cap_len`; `done` sets.
  - Any state → IDLE on `abort`; `done` stays clear.
  - `abort` has priority over `start`, trigger and write in the same cycle.
  - `start` outside IDLE is ignored.
- Trigger evaluation is done only on cycles with `smp_valid`=1, using sample `s` from the latched channel:
  - Immediate: first valid sample in ARMED.
  - Rising: `prev` < `trig_level` and `s` ≥ `trig_level`; unsigned compare.
  - Falling: `prev` ≥ `trig_level` and `s` < `trig_level`.
  - External: `ext_trig`=1 in the same cycle as `smp_valid`.
  - The `prev` register loads on every valid sample in ARMED. Modes 1 and 2 cannot fire on the first valid sample after arming.
- In CAPTURE, each valid sample is written at the next address; there are no gaps and invalid cycles are skipped.
- The address counter resets to 0 on arm. It never wraps within a capture, because `cap_len` is less than 2^ADDR_W.

## Timing
- All outputs are registered.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `armed`=0, `done`=0. State resets to IDLE.
- `start` at cycle t gives `busy`=`armed`=1 at t+1.
- Write latency: a sample accepted at cycle t (`smp_valid`=1) appears as `mem_we`=1 with its address and data at t+1.
- `done` and `busy`=0 assert in the same cycle as the final `mem_we`.
- `abort` at t gives `busy`=0 at t+1. No `mem_we` is issued at t+1 for a sample presented at t.
- Throughput: one write per cycle when `smp_valid` is held high.
- An asynchronous `rst` mid-capture returns all outputs to their reset values immediately.

## Structure
- Package `adc_cap_pkg` holds:
  - the state enum `cap_state_t` (IDLE, ARMED, CAPTURE);
  - the `trig_mode_t` enum and its constants TRIG_IMM=0, TRIG_RISE=1, TRIG_FALL=2, TRIG_EXT=3.
- Sub-module `adc_trig_detect` contains the channel mux, the `prev` register, the prev-valid flag and the comparators. It outputs a one-bit `trig_hit`, qualified by `smp_valid`.
- The top level contains the FSM, the address counter and the output registers.

## Test plan
- Immediate mode, `cap_len`=3, `smp_valid` always high, ch0 = 0,1,2… → exactly 4 `mem_we` at addresses 0–3 with ch0 data 0–3. `done`=1 on the last write and `busy`=0 on the same cycle.
- Rising mode, `trig_level`=0x800, ch1 ramp 0x7FE, 0x7FF, 0x800, 0x801 → first write is at address 0 with ch1=0x800.
  - Repeat with ch1 already at 0x900 when armed → no trigger until the signal drops below 0x800 and recrosses.
- Falling mode with `smp_valid` toggling every other cycle → writes occur only one cycle after valid samples, and addresses stay contiguous.
- External mode, `ext_trig` high on a cycle without `smp_valid` → no trigger; the next coincident `smp_valid` triggers.
- `abort` and `start` in the same cycle mid-capture → IDLE, no further `mem_we`, `done`=0. A later `start` restarts at address 0.
- `start` while busy is ignored, and the latched configuration is unchanged.
- `rst` asserted during CAPTURE → all outputs are 0 at once, with no spurious `mem_we` after release.
- `cap_len`=0 → a single write at address 0, with `done` set on that same write.
